// File: rtl/neuron_sequencer.sv
// Sequences image/weight fetches over two Avalon-MM masters, accumulates a signed dot product, writes the result.
// Optional build macro NEURON_RELU_EN clamps negative results to zero at write-back.
module neuron_sequencer #(
   parameter int unsigned OPERAND_W = 16
) (
   input  logic        clk_clk,
   input  logic        reset_reset,
   input  logic        control_start,
   input  logic        control_clear,
   input  logic [31:0] control_base_addr,
   input  logic [7:0]  control_kernel_size,
   output logic        control_done,
   output logic        img_read,
   output logic        img_write,
   output logic [29:0] img_address,
   output logic [31:0] img_writedata,
   input  logic [31:0] img_readdata,
   input  logic        img_waitrequest,
   output logic        weight_read,
   output logic [29:0] weight_address,
   input  logic [31:0] weight_readdata,
   input  logic        weight_waitrequest
);

   localparam int unsigned ADDR_W = 30;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 8;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_RD_IMG = 3'd1;
   localparam logic [2:0] S_RD_WGT = 3'd2;
   localparam logic [2:0] S_MAC    = 3'd3;
   localparam logic [2:0] S_WR     = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   logic [2:0]               r_state;
   logic [ADDR_W-1:0]        r_base;
   logic [CNT_W-1:0]         r_n;
   logic [CNT_W-1:0]         r_idx;
   logic signed [DATA_W-1:0] r_acc;
   logic [OPERAND_W-1:0]     r_img;
   logic [OPERAND_W-1:0]     r_wgt;
   logic                     r_done;
   logic                     r_img_read;
   logic                     r_img_write;
   logic [ADDR_W-1:0]        r_img_address;
   logic [DATA_W-1:0]        r_img_writedata;
   logic                     r_weight_read;
   logic [ADDR_W-1:0]        r_weight_address;

   logic [2:0]               w_state_nxt;
   logic [ADDR_W-1:0]        w_base_nxt;
   logic [CNT_W-1:0]         w_n_nxt;
   logic [CNT_W-1:0]         w_idx_nxt;
   logic signed [DATA_W-1:0] w_acc_nxt;
   logic [OPERAND_W-1:0]     w_img_nxt;
   logic [OPERAND_W-1:0]     w_wgt_nxt;
   logic                     w_done_nxt;
   logic                     w_img_read_nxt;
   logic                     w_img_write_nxt;
   logic [ADDR_W-1:0]        w_img_address_nxt;
   logic [DATA_W-1:0]        w_img_writedata_nxt;
   logic                     w_weight_read_nxt;
   logic [ADDR_W-1:0]        w_weight_address_nxt;

   logic signed [OPERAND_W-1:0] w_img_op;
   logic signed [OPERAND_W-1:0] w_wgt_op;
   logic signed [DATA_W-1:0]    w_img_ext;
   logic signed [DATA_W-1:0]    w_wgt_ext;
   logic signed [DATA_W-1:0]    w_prod;
   logic                        w_unused_bits;

   // Only the low OPERAND_W bits of each fetched word and the word-aligned base are meaningful.
   assign w_unused_bits = ^{img_readdata[DATA_W-1:OPERAND_W], weight_readdata[DATA_W-1:OPERAND_W],
                            control_base_addr[1:0]};

   assign w_img_op  = r_img;
   assign w_wgt_op  = r_wgt;
   assign w_img_ext = DATA_W'(w_img_op);
   assign w_wgt_ext = DATA_W'(w_wgt_op);
   assign w_prod    = w_img_ext * w_wgt_ext;

   function automatic logic [DATA_W-1:0] f_result(input logic signed [DATA_W-1:0] a);
`ifdef NEURON_RELU_EN
      f_result = a[DATA_W-1] ? '0 : a;
`else
      f_result = a;
`endif
   endfunction

   // Next-state logic; bus outputs are derived from the next state so they are registered and stable.
   always_comb begin
      w_state_nxt = r_state;
      w_base_nxt  = r_base;
      w_n_nxt     = r_n;
      w_idx_nxt   = r_idx;
      w_acc_nxt   = r_acc;
      w_img_nxt   = r_img;
      w_wgt_nxt   = r_wgt;

      if (control_clear) begin
         w_state_nxt = S_IDLE;
         w_acc_nxt   = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (control_start) begin
                  w_base_nxt  = control_base_addr[31:2];
                  w_n_nxt     = control_kernel_size;
                  w_idx_nxt   = '0;
                  w_acc_nxt   = '0;
                  w_state_nxt = (control_kernel_size != '0) ? S_RD_IMG : S_WR;
               end
            end
            S_RD_IMG: begin
               if (!img_waitrequest) begin
                  w_img_nxt   = img_readdata[OPERAND_W-1:0];
                  w_state_nxt = S_RD_WGT;
               end
            end
            S_RD_WGT: begin
               if (!weight_waitrequest) begin
                  w_wgt_nxt   = weight_readdata[OPERAND_W-1:0];
                  w_state_nxt = S_MAC;
               end
            end
            S_MAC: begin
               w_acc_nxt   = r_acc + w_prod;
               w_idx_nxt   = r_idx + CNT_W'(1);
               w_state_nxt = ((9'(r_idx) + 9'd1) < 9'(r_n)) ? S_RD_IMG : S_WR;
            end
            S_WR: begin
               if (!img_waitrequest) w_state_nxt = S_DONE;
            end
            S_DONE: w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
         endcase
      end

      w_done_nxt           = 1'b0;
      w_img_read_nxt       = 1'b0;
      w_img_write_nxt      = 1'b0;
      w_img_address_nxt    = '0;
      w_img_writedata_nxt  = '0;
      w_weight_read_nxt    = 1'b0;
      w_weight_address_nxt = '0;
      case (w_state_nxt)
         S_RD_IMG: begin
            w_img_read_nxt    = 1'b1;
            w_img_address_nxt = w_base_nxt + ADDR_W'(w_idx_nxt);
         end
         S_RD_WGT: begin
            w_weight_read_nxt    = 1'b1;
            w_weight_address_nxt = ADDR_W'(w_idx_nxt);
         end
         S_WR: begin
            w_img_write_nxt     = 1'b1;
            w_img_address_nxt   = w_base_nxt + ADDR_W'(w_n_nxt);
            w_img_writedata_nxt = f_result(w_acc_nxt);
         end
         S_DONE: w_done_nxt = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         r_state          <= S_IDLE;
         r_base           <= '0;
         r_n              <= '0;
         r_idx            <= '0;
         r_acc            <= '0;
         r_img            <= '0;
         r_wgt            <= '0;
         r_done           <= 1'b0;
         r_img_read       <= 1'b0;
         r_img_write      <= 1'b0;
         r_img_address    <= '0;
         r_img_writedata  <= '0;
         r_weight_read    <= 1'b0;
         r_weight_address <= '0;
      end else begin
         r_state          <= w_state_nxt;
         r_base           <= w_base_nxt;
         r_n              <= w_n_nxt;
         r_idx            <= w_idx_nxt;
         r_acc            <= w_acc_nxt;
         r_img            <= w_img_nxt;
         r_wgt            <= w_wgt_nxt;
         r_done           <= w_done_nxt;
         r_img_read       <= w_img_read_nxt;
         r_img_write      <= w_img_write_nxt;
         r_img_address    <= w_img_address_nxt;
         r_img_writedata  <= w_img_writedata_nxt;
         r_weight_read    <= w_weight_read_nxt;
         r_weight_address <= w_weight_address_nxt;
      end
   end

   assign control_done   = r_done;
   assign img_read       = r_img_read;
   assign img_write      = r_img_write;
   assign img_address    = r_img_address;
   assign img_writedata  = r_img_writedata;
   assign weight_read    = r_weight_read;
   assign weight_address = r_weight_address;

endmodule

// File: tb/tb_neuron_sequencer.sv
// Scoreboard bench for neuron_sequencer: stimulus pushes expected bus transfers, a negedge monitor pops and compares.
module tb_neuron_sequencer;

   logic        clk_clk = 1'b0;
   logic        reset_reset;
   logic        control_start;
   logic        control_clear;
   logic [31:0] control_base_addr;
   logic [7:0]  control_kernel_size;
   logic        control_done;
   logic        img_read;
   logic        img_write;
   logic [29:0] img_address;
   logic [31:0] img_writedata;
   logic [31:0] img_readdata;
   logic        img_waitrequest;
   logic        weight_read;
   logic [29:0] weight_address;
   logic [31:0] weight_readdata;
   logic        weight_waitrequest;

   always #5 clk_clk = ~clk_clk;

   neuron_sequencer dut (
      .clk_clk             (clk_clk),
      .reset_reset         (reset_reset),
      .control_start       (control_start),
      .control_clear       (control_clear),
      .control_base_addr   (control_base_addr),
      .control_kernel_size (control_kernel_size),
      .control_done        (control_done),
      .img_read            (img_read),
      .img_write           (img_write),
      .img_address         (img_address),
      .img_writedata       (img_writedata),
      .img_readdata        (img_readdata),
      .img_waitrequest     (img_waitrequest),
      .weight_read         (weight_read),
      .weight_address      (weight_address),
      .weight_readdata     (weight_readdata),
      .weight_waitrequest  (weight_waitrequest)
   );

   logic [31:0] img_mem [256];
   logic [31:0] wgt_mem [256];
   int          stall_used   = 0;
   int          stall_budget = 0;
   logic        img_hold = 1'b0;
   logic        wgt_hold = 1'b0;

   assign img_readdata       = img_mem[img_address[7:0]];
   assign weight_readdata    = wgt_mem[weight_address[7:0]];
   assign img_waitrequest    = img_hold || (img_read && (stall_used < stall_budget));
   assign weight_waitrequest = wgt_hold;

   always @(posedge clk_clk) if (img_read && img_waitrequest && !img_hold) stall_used <= stall_used + 1;

   typedef struct packed {
      logic [29:0] a;
      logic [31:0] d;
   } wr_t;

   logic [29:0] q_img_rd [$];
   logic [29:0] q_wgt_rd [$];
   wr_t         q_wr     [$];

   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
   endtask

   task automatic unexpected(input string nm, input logic [29:0] addr);
      n_total++;
      $display("FAIL %s: unexpected transfer at address 0x%08h", nm, 32'(addr));
   endtask

   // Monitor: every completed transfer must match the head of its scoreboard queue.
   logic        prev_stall = 1'b0;
   logic [29:0] prev_addr  = '0;
   always @(negedge clk_clk) begin
      if (!reset_reset) begin
         if (img_read || img_write || weight_read)
            check("one_strobe", 32'(img_read) + 32'(img_write) + 32'(weight_read), 32'd1);
         if (prev_stall) begin
            check("stall_read_held", 32'(img_read), 32'd1);
            check("stall_addr_held", 32'(img_address), 32'(prev_addr));
         end
         if (img_read && !img_waitrequest) begin
            if (q_img_rd.size() == 0) unexpected("img_rd", img_address);
            else check("img_rd_addr", 32'(img_address), 32'(q_img_rd.pop_front()));
         end
         if (weight_read && !weight_waitrequest) begin
            if (q_wgt_rd.size() == 0) unexpected("wgt_rd", weight_address);
            else check("wgt_rd_addr", 32'(weight_address), 32'(q_wgt_rd.pop_front()));
         end
         if (img_write && !img_waitrequest) begin
            if (q_wr.size() == 0) unexpected("img_wr", img_address);
            else begin
               wr_t e;
               e = q_wr.pop_front();
               check("wr_addr", 32'(img_address), 32'(e.a));
               check("wr_data", img_writedata, e.d);
            end
         end
         prev_stall = img_read && img_waitrequest;
         prev_addr  = img_address;
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) begin
         img_mem[i] = '0;
         wgt_mem[i] = '0;
      end
   endtask

   task automatic load_basic();
      clear_mem();
      img_mem[8'h40] = 32'd2;
      img_mem[8'h41] = 32'd3;
      img_mem[8'h42] = 32'd4;
      wgt_mem[0] = 32'd5;
      wgt_mem[1] = 32'hFFFF_FFFF;
      wgt_mem[2] = 32'd2;
   endtask

   task automatic start_op(input logic [31:0] base, input int n);
      @(negedge clk_clk);
      control_base_addr   = base;
      control_kernel_size = 8'(n);
      control_start       = 1'b1;
      @(negedge clk_clk);
      control_start = 1'b0;
   endtask

   // Push expected transfers, run one evaluation, check latency, done hold and clear.
   task automatic run_case(input string nm, input logic [31:0] base, input int n,
                           input logic [31:0] exp_d, input int exp_lat);
      logic [29:0] b;
      int          cyc;
      wr_t         w;
      b = base[31:2];
      for (int i = 0; i < n; i++) begin
         q_img_rd.push_back(b + 30'(i));
         q_wgt_rd.push_back(30'(i));
      end
      w.a = b + 30'(n);
      w.d = exp_d;
      q_wr.push_back(w);
      start_op(base, n);
      cyc = 1;
      while (!control_done && cyc < 400) begin
         @(negedge clk_clk);
         cyc++;
      end
      check({nm, "_latency"}, 32'(cyc), 32'(exp_lat));
      @(negedge clk_clk);
      check({nm, "_done_held"}, 32'(control_done), 32'd1);
      control_clear = 1'b1;
      @(negedge clk_clk);
      control_clear = 1'b0;
      check({nm, "_done_cleared"}, 32'(control_done), 32'd0);
   endtask

   initial begin
      int k;
      reset_reset         = 1'b1;
      control_start       = 1'b0;
      control_clear       = 1'b0;
      control_base_addr   = '0;
      control_kernel_size = '0;
      clear_mem();
      repeat (3) @(negedge clk_clk);
      check("rst_done",      32'(control_done),   32'd0);
      check("rst_img_read",  32'(img_read),       32'd0);
      check("rst_img_write", 32'(img_write),      32'd0);
      check("rst_wgt_read",  32'(weight_read),    32'd0);
      check("rst_img_addr",  32'(img_address),    32'd0);
      check("rst_wgt_addr",  32'(weight_address), 32'd0);
      check("rst_wdata",     img_writedata,       32'd0);
      reset_reset = 1'b0;
      repeat (2) @(negedge clk_clk);

      // 2*5 + 3*-1 + 4*2 = 15
      load_basic();
      run_case("n3", 32'h100, 3, 32'd15, 11);

      clear_mem();
      run_case("n0", 32'h20, 0, 32'd0, 2);

      load_basic();
      stall_budget = stall_used + 4;
      run_case("stall", 32'h100, 3, 32'd15, 15);

      clear_mem();
      img_mem[8'h80] = 32'hFFFF_FFFD;
      wgt_mem[0]     = 32'd7;
`ifdef NEURON_RELU_EN
      run_case("neg", 32'h200, 1, 32'd0, 5);
`else
      run_case("neg", 32'h200, 1, 32'hFFFF_FFEB, 5);
`endif

      // Upper bits ignored; 3*-2 + (-32768)*(-32768) = 0x3FFFFFFA
      clear_mem();
      img_mem[8'hC0] = 32'h1234_0003;
      img_mem[8'hC1] = 32'h0000_8000;
      wgt_mem[0]     = 32'hABCD_FFFE;
      wgt_mem[1]     = 32'h0000_8000;
      run_case("trunc", 32'h300, 2, 32'h3FFF_FFFA, 8);

      // Clear while the second weight read is stalled
      load_basic();
      q_img_rd.push_back(30'h40);
      q_wgt_rd.push_back(30'h0);
      q_img_rd.push_back(30'h41);
      start_op(32'h100, 3);
      k = 0;
      while (!(img_read && img_address == 30'h41) && k < 50) begin
         @(negedge clk_clk);
         k++;
      end
      check("clr_reached_pair2", 32'(k < 50), 32'd1);
      wgt_hold = 1'b1;
      @(negedge clk_clk);
      check("clr_wgt_read", 32'(weight_read), 32'd1);
      check("clr_wgt_addr", 32'(weight_address), 32'd1);
      control_clear = 1'b1;
      @(negedge clk_clk);
      control_clear = 1'b0;
      wgt_hold      = 1'b0;
      check("clr_strobes", 32'({img_read, img_write, weight_read}), 32'd0);
      check("clr_done", 32'(control_done), 32'd0);
      repeat (5) @(negedge clk_clk);
      check("clr_idle_strobes", 32'({img_read, img_write, weight_read}), 32'd0);
      run_case("fresh", 32'h100, 3, 32'd15, 11);

      // Reset during a stalled write
      clear_mem();
      img_hold = 1'b1;
      start_op(32'h20, 0);
      k = 0;
      while (!img_write && k < 20) begin
         @(negedge clk_clk);
         k++;
      end
      check("rstwr_write_seen", 32'(img_write), 32'd1);
      check("rstwr_addr", 32'(img_address), 32'h8);
      reset_reset = 1'b1;
      #1;
      check("rstwr_write_drop", 32'(img_write), 32'd0);
      check("rstwr_done", 32'(control_done), 32'd0);
      check("rstwr_addr_zero", 32'(img_address), 32'd0);
      @(negedge clk_clk);
      reset_reset = 1'b0;
      img_hold    = 1'b0;
      repeat (5) @(negedge clk_clk);
      check("rstwr_no_write", 32'(img_write), 32'd0);
      run_case("after_rst", 32'h20, 0, 32'd0, 2);

      repeat (3) @(negedge clk_clk);
      check("q_img_empty", 32'(q_img_rd.size()), 32'd0);
      check("q_wgt_empty", 32'(q_wgt_rd.size()), 32'd0);
      check("q_wr_empty",  32'(q_wr.size()),     32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/neuron_sequencer.md
NEURON_SEQUENCER -- requirements
Module: neuron_sequencer

Interface
REQ-001 Parameter: OPERAND_W, 16, signed operand width taken from bits [OPERAND_W-1:0] of each fetched word; legal 2..16.
REQ-002 clk_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_reset  input  1  asynchronous, active-high reset.
REQ-004 control_start  input  1  request to begin one neuron evaluation.
REQ-005 control_clear  input  1  abort, or acknowledge done; returns the block to IDLE.
REQ-006 control_base_addr  input  32  byte base address of the image window.
REQ-007 control_kernel_size  input  8  number of image/weight pairs N (0..255).
REQ-008 control_done  output  1  evaluation complete and result written.
REQ-009 img_read, img_write  output  1 each  Avalon-MM master strobes to the image memory.
REQ-010 img_address  output  30  word address to the image memory.
REQ-011 img_writedata  output  32  result word.
REQ-012 img_readdata  input  32  image read data.
REQ-013 img_waitrequest  input  1  image memory stall.
REQ-014 weight_read  output  1  weight read strobe; this block never writes weights.
REQ-015 weight_address  output  30  weight word address.
REQ-016 weight_readdata  input  32  weight read data.
REQ-017 weight_waitrequest  input  1  weight memory stall.

Function
REQ-018 FSM states: IDLE, RD_IMG, RD_WGT, MAC, WR, DONE.
REQ-019 IDLE, control_start=1 -> latch base=control_base_addr[31:2], N=control_kernel_size; i=0; acc=0; next state RD_IMG if N!=0, otherwise WR.
REQ-020 control_start is ignored in every state other than IDLE.
REQ-021 RD_IMG: img_read=1 and img_address=base+i (mod 2^30), both held stable while img_waitrequest=1; on the first cycle with waitrequest=0, capture img_readdata and go to RD_WGT.
REQ-022 RD_WGT: weight_read=1 and weight_address=i, held stable while weight_waitrequest=1; on the first cycle with waitrequest=0, capture weight_readdata and go to MAC.
REQ-023 Read data is valid in the same cycle that waitrequest=0; the interface uses zero-latency reads with no readdatavalid.
REQ-024 MAC, one cycle: acc += sext(img[OPERAND_W-1:0]) * sext(wgt[OPERAND_W-1:0]), computed as signed 32-bit with two's-complement wrap and no saturation; i++; next state RD_IMG if i+1<N, otherwise WR.
REQ-025 WR: img_write=1, img_address=base+N (mod 2^30), img_writedata=result, all held stable while img_waitrequest=1; the first cycle with waitrequest=0 completes the write and moves to DONE.
REQ-026 DONE: control_done=1, held until control_clear=1; the state then returns to IDLE.
REQ-027 control_clear=1 in any state -> IDLE next cycle, acc=0, all strobes low; an in-flight stalled transfer is dropped.
REQ-028 control_clear takes priority over control_start when both are high in the same cycle.
REQ-029 At most one of img_read, img_write, weight_read is high in any cycle; img_read and img_write are never high together.
REQ-030 With zero waitrequest, each pair takes 3 cycles; total latency from start to control_done=1 is 3N+2 cycles.

Reset
REQ-031 While reset_reset=1: state=IDLE; control_done=0; all read and write strobes=0; all addresses, img_writedata, acc, i, and N=0.
REQ-032 Reset asserted mid-transfer abandons the transfer immediately; no write strobe is issued after reset is released until a new start.

Configuration
REQ-033 NEURON_RELU_EN defined -> result=(acc<0)?0:acc at WR; undefined -> result=acc unmodified. No other behaviour differs between the two builds.

Verification
REQ-034 N=3, base=0x100, img words {2,3,4}, weights {5,-1,2}, no stalls -> reads at img addr 0x40..0x42 and wgt addr 0..2; write 15 to img addr 0x43; done exactly at cycle 11.
REQ-035 N=0, base=0x20 -> no reads; write 0 to addr 0x8; done after 2 cycles.
REQ-036 img_waitrequest held high 4 cycles on the first read -> address and read stay stable; final result unchanged; done 4 cycles later than the no-stall case.
REQ-037 N=1, img=-3, wgt=7 -> write -21 (0xFFFFFFEB); with NEURON_RELU_EN defined, write 0.
REQ-038 control_clear pulsed during RD_WGT of pair 2 -> IDLE next cycle with no write issued; a new start then gives a correct fresh result (acc restarted from 0).
REQ-039 reset_reset asserted during WR with img_waitrequest=1 -> img_write=0 immediately; control_done=0; state IDLE.
